// File: rtl/interrupt_sequencer.sv
// 6502-style interrupt entry: push PCH, PCL and P, fetch the vector, then load the new PC.
// Define INT_SEQ_NMI_EN to build in the falling-edge NMI input; without it only IRQ/BRK (vector FFFE) exist.
module interrupt_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq_n,
  input  logic        nmi_n,
  input  logic        brk_req,
  input  logic        instr_boundary,
  input  logic        flag_carry,
  input  logic        flag_zero,
  input  logic        flag_negative,
  input  logic        flag_overflow,
  input  logic        flag_interrupt_disable,
  input  logic [15:0] pc_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  data_in,
  output logic [15:0] addr_out,
  output logic        write_en,
  output logic        read_en,
  output logic [7:0]  data_out,
  output logic        sp_dec,
  output logic        set_interrupt_disable,
  output logic        pc_load,
  output logic [15:0] pc_out,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    PUSH_PCH,
    PUSH_PCL,
    PUSH_P,
    FETCH_LO,
    FETCH_HI,
    LOAD_PC
  } state_t;

  state_t      state;
  logic [15:0] pc_save;
  logic [7:0]  p_save;
  logic [7:0]  lo_byte;
  logic [15:0] vector;
  logic        can_accept;
  logic        take_nmi;
  logic        take_brk;
  logic        take_irq;
  logic        accept;

  assign can_accept = (state == IDLE) && instr_boundary;

`ifdef INT_SEQ_NMI_EN
  logic nmi_prev;
  logic nmi_pending;
  logic nmi_edge;
  logic vec_nmi;

  assign nmi_edge = nmi_prev && !nmi_n;
  assign take_nmi = can_accept && nmi_pending;

  // An edge seen in the accepting cycle survives the clear and is served next time.
  always_ff @(posedge clk) begin
    if (reset) begin
      nmi_prev    <= 1'b1;
      nmi_pending <= 1'b0;
    end else begin
      nmi_prev    <= nmi_n;
      nmi_pending <= nmi_edge || (nmi_pending && !take_nmi);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) vec_nmi <= take_nmi;
  end

  assign vector = vec_nmi ? 16'hFFFA : 16'hFFFE;
`else
  logic unused_nmi;

  assign unused_nmi = nmi_n;
  assign take_nmi   = 1'b0;
  assign vector     = 16'hFFFE;
`endif

  assign take_brk = can_accept && !take_nmi && brk_req;
  assign take_irq = can_accept && !take_nmi && !brk_req && !irq_n && !flag_interrupt_disable;
  assign accept   = take_nmi || take_brk || take_irq;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:     if (accept) state <= PUSH_PCH;
        PUSH_PCH: state <= PUSH_PCL;
        PUSH_PCL: state <= PUSH_P;
        PUSH_P:   state <= FETCH_LO;
        FETCH_LO: state <= FETCH_HI;
        FETCH_HI: state <= LOAD_PC;
        LOAD_PC:  state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Snapshot taken at acceptance so later flag or PC changes cannot leak into the stack image.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_save <= pc_in;
      p_save  <= {flag_negative, flag_overflow, 1'b1, take_brk, 1'b0,
                  flag_interrupt_disable, flag_zero, flag_carry};
    end
    if (state == FETCH_HI) lo_byte <= data_in;
  end

  always_comb begin
    addr_out              = 16'h0000;
    write_en              = 1'b0;
    read_en               = 1'b0;
    data_out              = 8'h00;
    sp_dec                = 1'b0;
    set_interrupt_disable = 1'b0;
    pc_load               = 1'b0;
    pc_out                = 16'h0000;
    busy                  = (state != IDLE);
    case (state)
      PUSH_PCH: begin
        addr_out = {8'h01, sp_in};
        write_en = 1'b1;
        sp_dec   = 1'b1;
        data_out = pc_save[15:8];
      end
      PUSH_PCL: begin
        addr_out = {8'h01, sp_in};
        write_en = 1'b1;
        sp_dec   = 1'b1;
        data_out = pc_save[7:0];
      end
      PUSH_P: begin
        addr_out              = {8'h01, sp_in};
        write_en              = 1'b1;
        sp_dec                = 1'b1;
        data_out              = p_save;
        set_interrupt_disable = 1'b1;
      end
      FETCH_LO: begin
        addr_out = vector;
        read_en  = 1'b1;
      end
      FETCH_HI: begin
        addr_out = {vector[15:1], 1'b1};
        read_en  = 1'b1;
      end
      LOAD_PC: begin
        pc_load = 1'b1;
        pc_out  = {data_in, lo_byte};
      end
      default: ;
    endcase
  end

endmodule
